// File: rtl/regset_writeback.sv
// Writeback arbiter for the 32 x 32-bit register set: merges the never-stalled ALU
// result with an in-order load FIFO and reports per-register pending-write flags.
module regset_writeback #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [4:0]      A_Q0,
    input  logic [4:0]      A_Q1,
    input  logic [4:0]      A_QD,
    output logic            busy_Q0,
    output logic            busy_Q1,
    output logic            busy_QD,
    output logic [XLEN-1:0] D,
    output logic [4:0]      A_D,
    output logic            write_enable,
    output logic [CW-1:0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0]  data_mem [DEPTH];
    logic [4:0]       rd_mem   [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             alu_sel;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] occupied;

    // ALU wins the port; x0 destinations are discarded so they never block a pop.
    assign ld_ready = (fifo_count < CW'(DEPTH));
    assign alu_sel  = alu_valid && (alu_rd != 5'd0);
    assign pop      = !alu_sel && (fifo_count != '0);
    assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                rd_mem[i]   <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= ld_data;
                rd_mem[wr_ptr]   <= ld_rd;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // D and A_D hold their last value on idle cycles; only the strobe drops.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            D            <= '0;
            A_D          <= '0;
            write_enable <= 1'b0;
        end else if (alu_sel) begin
            D            <= alu_data;
            A_D          <= alu_rd;
            write_enable <= 1'b1;
        end else if (pop) begin
            D            <= data_mem[rd_ptr];
            A_D          <= rd_mem[rd_ptr];
            write_enable <= 1'b1;
        end else begin
            write_enable <= 1'b0;
        end
    end

    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = CW'(PW'(i) - rd_ptr) < fifo_count;
        end
    end

    function automatic logic query_busy(input logic [4:0] q);
        logic hit;
        hit = write_enable && (A_D == q);
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (rd_mem[i] == q)) begin
                hit = 1'b1;
            end
        end
        return hit && (q != 5'd0);
    endfunction

    always_comb begin
        busy_Q0 = query_busy(A_Q0);
        busy_Q1 = query_busy(A_Q1);
        busy_QD = query_busy(A_QD);
    end

endmodule

// File: tb/tb_regset_writeback.sv
// Directed bench for regset_writeback: queue-based reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_regset_writeback;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic            CLK;
    logic            RES;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [4:0]      A_Q0;
    logic [4:0]      A_Q1;
    logic [4:0]      A_QD;
    logic            busy_Q0;
    logic            busy_Q1;
    logic            busy_QD;
    logic [XLEN-1:0] D;
    logic [4:0]      A_D;
    logic            write_enable;
    logic [CW-1:0]   fifo_count;

    regset_writeback #(.XLEN(XLEN), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RES(RES),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .A_Q0(A_Q0), .A_Q1(A_Q1), .A_QD(A_QD),
        .busy_Q0(busy_Q0), .busy_Q1(busy_Q1), .busy_QD(busy_QD),
        .D(D), .A_D(A_D), .write_enable(write_enable), .fifo_count(fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests  = 0;
    int errors = 0;
    bit started = 1'b0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          mq[$];
    logic            m_we;
    logic [4:0]      m_ad;
    logic [XLEN-1:0] m_d;
    logic            alu_ok;
    logic            ld_take;

    assign alu_ok  = alu_valid && (alu_rd != 5'd0);
    assign ld_take = ld_valid && (ld_rd != 5'd0) && (mq.size() < DEPTH);

    // Reference model: ALU first, else oldest queued load; loads accepted while not full.
    always @(posedge CLK or posedge RES) begin
        if (RES) begin
            mq.delete();
            m_we <= 1'b0;
            m_ad <= '0;
            m_d  <= '0;
        end else begin
            if (alu_ok) begin
                m_we <= 1'b1;
                m_ad <= alu_rd;
                m_d  <= alu_data;
            end else if (mq.size() > 0) begin
                m_we <= 1'b1;
                m_ad <= mq[0].rd;
                m_d  <= mq[0].data;
            end else begin
                m_we <= 1'b0;
            end
            if (!alu_ok && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (ld_take) begin
                mq.push_back({ld_rd, ld_data});
            end
        end
    end

    function automatic logic exp_busy(input logic [4:0] a);
        logic hit;
        hit = m_we && (m_ad == a);
        foreach (mq[i]) begin
            if (mq[i].rd == a) hit = 1'b1;
        end
        return hit && (a != 5'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge; drives inputs for exactly one rising edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        #1;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        @(negedge CLK);
    endtask

    task automatic setQuery(input logic [4:0] q0, input logic [4:0] q1, input logic [4:0] qd);
        #1;
        A_Q0 = q0;
        A_Q1 = q1;
        A_QD = qd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    always @(negedge CLK) begin
        if (started && !RES) begin
            checkOutput("cmp_we", write_enable, m_we);
            checkOutput("cmp_ad", A_D, m_ad);
            checkOutput("cmp_d", D, m_d);
            checkOutput("cmp_count", fifo_count, mq.size());
            checkOutput("cmp_ready", ld_ready, mq.size() < DEPTH);
            checkOutput("cmp_busy0", busy_Q0, exp_busy(A_Q0));
            checkOutput("cmp_busy1", busy_Q1, exp_busy(A_Q1));
            checkOutput("cmp_busyd", busy_QD, exp_busy(A_QD));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RES = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        A_Q0 = '0; A_Q1 = '0; A_QD = '0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_we", write_enable, 0);
        checkOutput("rst_ad", A_D, 0);
        checkOutput("rst_d", D, 0);
        checkOutput("rst_count", fifo_count, 0);
        RES = 1'b0;
        started = 1'b1;
        idle();
        checkOutput("rel_ready", ld_ready, 1);

        // ALU path latency
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0);
        checkOutput("alu_we", write_enable, 1);
        checkOutput("alu_ad", A_D, 5);
        checkOutput("alu_d", D, 32'h12345678);
        idle();
        checkOutput("alu_idle_we", write_enable, 0);
        checkOutput("alu_hold_d", D, 32'h12345678);

        // Load queue and drain, busy tracking on rd=4
        setQuery(5'd4, 5'd3, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hA);
        checkOutput("ld1_count", fifo_count, 1);
        checkOutput("ld1_busy1", busy_Q1, 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hB);
        checkOutput("ld2_ad", A_D, 3);
        checkOutput("ld2_d", D, 32'hA);
        checkOutput("ld2_busy0", busy_Q0, 1);
        idle();
        checkOutput("ld3_ad", A_D, 4);
        checkOutput("ld3_d", D, 32'hB);
        checkOutput("ld3_busy0", busy_Q0, 1);
        idle();
        checkOutput("ld4_we", write_enable, 0);
        checkOutput("ld4_busy0", busy_Q0, 0);

        // Priority and starvation
        setQuery(5'd9, 5'd0, 5'd7);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 5'd7, 32'h700 + i, 1'b1, 5'(8 + i), 32'hB00 + i);
        end
        checkOutput("full_count", fifo_count, 4);
        checkOutput("full_ready", ld_ready, 0);
        checkOutput("full_ad", A_D, 7);
        checkOutput("full_busy0", busy_Q0, 1);
        checkOutput("full_busyd", busy_QD, 1);
        applyStimulus(1'b1, 5'd7, 32'h704, 1'b1, 5'd12, 32'hC0C);
        checkOutput("full2_count", fifo_count, 4);
        checkOutput("full2_d", D, 32'h704);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C);
        checkOutput("pop1_ad", A_D, 8);
        checkOutput("pop1_d", D, 32'hB00);
        checkOutput("pop1_count", fifo_count, 3);
        checkOutput("pop1_ready", ld_ready, 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0C);
        checkOutput("pop2_ad", A_D, 9);
        checkOutput("pop2_count", fifo_count, 3);
        repeat (4) idle();
        checkOutput("drain_we", write_enable, 0);
        checkOutput("drain_ad", A_D, 12);
        checkOutput("drain_d", D, 32'hC0C);

        // x0 handling
        setQuery(5'd0, 5'd13, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD);
        applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        checkOutput("x0_we", write_enable, 1);
        checkOutput("x0_ad", A_D, 13);
        checkOutput("x0_d", D, 32'hD);
        checkOutput("x0_busy0", busy_Q0, 0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h99);
        checkOutput("x0ld_we", write_enable, 0);
        checkOutput("x0ld_count", fifo_count, 0);
        idle();
        checkOutput("x0ld2_we", write_enable, 0);

        // Simultaneous push/pop across a pointer wrap
        setQuery(5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd1, 32'h111, 1'b1, 5'd20, 32'h2000);
        applyStimulus(1'b1, 5'd1, 32'h112, 1'b1, 5'd21, 32'h2001);
        checkOutput("pp_count0", fifo_count, 2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(22 + i), 32'h2002 + i);
            checkOutput("pp_ad", A_D, 20 + i);
            checkOutput("pp_d", D, 32'h2000 + i);
            checkOutput("pp_count", fifo_count, 2);
        end
        repeat (3) idle();
        checkOutput("pp_last_ad", A_D, 27);
        checkOutput("pp_last_we", write_enable, 0);

        // Asynchronous reset with loads queued
        applyStimulus(1'b1, 5'd2, 32'h222, 1'b1, 5'd28, 32'h2800);
        applyStimulus(1'b1, 5'd2, 32'h223, 1'b1, 5'd29, 32'h2900);
        #1;
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        @(posedge CLK);
        #2;
        RES = 1'b1;
        #1;
        checkOutput("arst_we", write_enable, 0);
        checkOutput("arst_ad", A_D, 0);
        checkOutput("arst_d", D, 0);
        checkOutput("arst_count", fifo_count, 0);
        @(negedge CLK);
        RES = 1'b0;
        idle();
        checkOutput("arst2_we", write_enable, 0);
        checkOutput("arst2_ready", ld_ready, 1);
        idle();
        checkOutput("arst3_we", write_enable, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
